// File: rtl/accel_pkg.sv
// Shared definitions for the matrix accelerator Wishbone driver:
// sequencer states, header word layout and fixed command words.
package accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_OPND = 3'd2,
        ST_GO   = 3'd3,
        ST_POLL = 3'd4,
        ST_RES  = 3'd5,
        ST_FIN  = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    // Header word indices inside the accelerator register window.
    localparam int unsigned HDR_OP         = 0;
    localparam int unsigned HDR_DIMS_FIRST = 1;
    localparam int unsigned HDR_DIMS_LAST  = 4;
    localparam int unsigned HDR_GO         = 5;

    localparam logic [31:0] GO_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] MATMUL  = 32'd1;

    // Byte address of a word index; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single-access Wishbone initiator: launches one request, holds it until
// ack or timeout, and always leaves at least one idle cycle between strobes.
module wb_master_port #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdat,
    output logic        ack,
    output logic [31:0] rdat,
    output logic        timeout,
    output logic        cyc,
    output logic        stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdat,
    input  logic [31:0] bus_rdat,
    input  logic        bus_ack
);

    localparam logic [31:0] LAST_WAIT = 32'(TIMEOUT - 1);

    logic        stb_q;
    logic [31:0] wait_cnt;

    // Ack is only honoured while strobing, so a stray ack in the gap is ignored.
    assign ack     = stb_q & bus_ack;
    assign rdat    = bus_rdat;
    assign timeout = stb_q & ~bus_ack & (wait_cnt == LAST_WAIT);
    assign cyc     = stb_q;
    assign stb     = stb_q;

    // A request is only taken while stb is low, which makes the cycle after
    // every completion a forced gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q    <= 1'b0;
            wait_cnt <= '0;
            bus_we   <= 1'b0;
            bus_adr  <= '0;
            bus_wdat <= '0;
        end else if (stb_q) begin
            if (ack || timeout) begin
                stb_q <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end else if (req) begin
            stb_q    <= 1'b1;
            wait_cnt <= '0;
            bus_we   <= req_we;
            bus_adr  <= req_adr;
            bus_wdat <= req_wdat;
        end
    end

endmodule

// File: rtl/wb_accel_driver.sv
// Runs one accelerator job: header, operands, go, poll, then result readout,
// sequencing single Wishbone accesses through wb_master_port.
module wb_accel_driver
    import accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3010_0000,
    parameter int unsigned OPND_IDX  = 6,
    parameter int unsigned RES_IDX   = 64,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op,
    input  logic [31:0] cmd_dims,
    input  logic [15:0] cmd_n_in,
    input  logic [15:0] cmd_n_out,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic [31:0] op_q;
    logic [31:0] dims_q;
    logic [15:0] n_in_q;
    logic [15:0] n_out_q;
    logic [15:0] cnt;

    logic        req;
    logic        req_we;
    logic [31:0] req_idx;
    logic [31:0] req_wdat;
    logic        ack;
    logic        timeout;
    logic [31:0] rdat;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_OPND) & ack;
    assign done      = (state == ST_FIN) & (~out_valid | out_ready);

    // Request for the access belonging to the current state and word count.
    always_comb begin
        req      = 1'b0;
        req_we   = 1'b1;
        req_idx  = '0;
        req_wdat = '0;
        case (state)
            ST_HDR: begin
                req     = 1'b1;
                req_idx = {16'b0, cnt};
                case (cnt[2:0])
                    3'd0:    req_wdat = op_q;
                    3'd1:    req_wdat = {24'b0, dims_q[7:0]};
                    3'd2:    req_wdat = {24'b0, dims_q[15:8]};
                    3'd3:    req_wdat = {24'b0, dims_q[23:16]};
                    default: req_wdat = {24'b0, dims_q[31:24]};
                endcase
            end
            ST_OPND: begin
                req      = in_valid;
                req_idx  = 32'(OPND_IDX) + {16'b0, cnt};
                req_wdat = in_data;
            end
            ST_GO: begin
                req      = 1'b1;
                req_idx  = 32'(HDR_GO);
                req_wdat = GO_WORD;
            end
            ST_POLL: begin
                req     = 1'b1;
                req_we  = 1'b0;
                req_idx = 32'(HDR_GO);
            end
            ST_RES: begin
                req     = ~out_valid;
                req_we  = 1'b0;
                req_idx = 32'(RES_IDX) + {16'b0, cnt};
            end
            default: ;
        endcase
    end

    wb_master_port #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .req      (req),
        .req_we   (req_we),
        .req_adr  (word_addr(BASE_ADDR, req_idx)),
        .req_wdat (req_wdat),
        .ack      (ack),
        .rdat     (rdat),
        .timeout  (timeout),
        .cyc      (wbm_cyc_o),
        .stb      (wbm_stb_o),
        .bus_we   (wbm_we_o),
        .bus_adr  (wbm_adr_o),
        .bus_wdat (wbm_dat_o),
        .bus_rdat (wbm_dat_i),
        .bus_ack  (wbm_ack_i)
    );

    // Job sequencer: advances on each completed access, aborts on timeout.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            dims_q    <= '0;
            n_in_q    <= '0;
            n_out_q   <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (timeout) begin
                state <= ST_ERR;
                err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (cmd_valid) begin
                        op_q    <= cmd_op;
                        dims_q  <= cmd_dims;
                        n_in_q  <= cmd_n_in;
                        n_out_q <= cmd_n_out;
                        cnt     <= '0;
                        err     <= 1'b0;
                        state   <= ST_HDR;
                    end
                    ST_HDR: if (ack) begin
                        if (cnt == 16'(HDR_DIMS_LAST)) begin
                            cnt   <= '0;
                            state <= (n_in_q == 16'd0) ? ST_GO : ST_OPND;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_OPND: if (ack) begin
                        if (cnt == n_in_q - 16'd1) begin
                            cnt   <= '0;
                            state <= ST_GO;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_GO: if (ack) begin
                        state <= ST_POLL;
                    end
                    ST_POLL: if (ack && rdat == 32'd0) begin
                        cnt   <= '0;
                        state <= (n_out_q == 16'd0) ? ST_FIN : ST_RES;
                    end
                    ST_RES: if (ack) begin
                        out_data  <= rdat;
                        out_valid <= 1'b1;
                        if (cnt == n_out_q - 16'd1) begin
                            state <= ST_FIN;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_FIN: if (!out_valid || out_ready) begin
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_accel_driver.sv
// Randomized scoreboard bench for wb_accel_driver with a Wishbone slave model.
`timescale 1ns/1ps
module tb_wb_accel_driver;
    import accel_pkg::*;

    localparam logic [31:0] BASE     = 32'h3010_0000;
    localparam int unsigned OPND_IDX = 6;
    localparam int unsigned RES_IDX  = 64;
    localparam int unsigned TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_op = '0, cmd_dims = '0;
    logic [15:0] cmd_n_in = '0, cmd_n_out = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] out_data;
    logic        out_valid, out_ready = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy, done, err;

    always #5 clk = ~clk;

    wb_accel_driver #(
        .BASE_ADDR (BASE),
        .OPND_IDX  (OPND_IDX),
        .RES_IDX   (RES_IDX),
        .TIMEOUT   (TMO)
    ) dut (
        .wb_clk_i  (clk),       .wb_rst_n_i (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready  (cmd_ready),
        .cmd_op    (cmd_op),    .cmd_dims   (cmd_dims),
        .cmd_n_in  (cmd_n_in),  .cmd_n_out  (cmd_n_out),
        .in_data   (in_data),   .in_valid   (in_valid),   .in_ready (in_ready),
        .out_data  (out_data),  .out_valid  (out_valid),  .out_ready (out_ready),
        .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o  (wbm_stb_o),  .wbm_we_o (wbm_we_o),
        .wbm_adr_o (wbm_adr_o), .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i), .wbm_ack_i  (wbm_ack_i),
        .busy      (busy),      .done       (done),       .err (err)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_t;

    acc_t        exp_bus[$];
    logic [31:0] exp_out[$];
    logic [31:0] opnd_q[$];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          poll_total = 0;
    int          poll_limit = 0;
    int          slave_lat = 1;
    int          wait_n = 0;
    bit          never_ack_go = 1'b0;
    logic [31:0] salt = '0;

    function automatic logic [31:0] waddr(input int unsigned idx);
        return BASE + 32'(idx) * 32'd4;
    endfunction

    function automatic logic [31:0] res_word(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B9) ^ s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Slave model: random ack latency, busy-then-idle status word, hashed result words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_ack_i <= 1'b0;
            wait_n    <= 0;
        end else begin
            wbm_ack_i <= 1'b0;
            if (wbm_stb_o && !wbm_ack_i) begin
                if (never_ack_go && wbm_we_o && wbm_adr_o == waddr(HDR_GO)) begin
                    wait_n <= 0;
                end else if (wait_n >= slave_lat) begin
                    wbm_ack_i <= 1'b1;
                    wait_n    <= 0;
                    slave_lat <= $urandom_range(0, 2);
                    if (!wbm_we_o && wbm_adr_o == waddr(HDR_GO)) begin
                        wbm_dat_i  <= (poll_total < poll_limit) ? 32'hFFFF_FFFF : 32'd0;
                        poll_total <= poll_total + 1;
                    end else if (!wbm_we_o) begin
                        wbm_dat_i <= res_word(wbm_adr_o, salt);
                    end else begin
                        wbm_dat_i <= $urandom;
                    end
                end else begin
                    wait_n <= wait_n + 1;
                end
            end
        end
    end

    // Monitor: bus scoreboard, gap/hold rules, result stream, done pulses.
    logic         prev_acc = 1'b0, prev_stb = 1'b0;
    logic [64:0]  prev_req = '0;
    always @(negedge clk) begin
        acc_t        e;
        logic [31:0] w;
        if (!rst_n) begin
            prev_acc = 1'b0;
            prev_stb = 1'b0;
        end else begin
            if (prev_acc) check("gap_after_ack", wbm_stb_o, 0);
            if (prev_stb && !prev_acc && wbm_stb_o)
                check("req_hold", {wbm_we_o, wbm_adr_o, wbm_dat_o}, prev_req);
            if (wbm_stb_o && wbm_ack_i) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_extra: unexpected access we=%0b adr=%h", wbm_we_o, wbm_adr_o);
                end else begin
                    e = exp_bus.pop_front();
                    if (e.we) check("bus_write", {wbm_we_o, wbm_adr_o, wbm_dat_o}, {e.we, e.adr, e.dat});
                    else      check("bus_read", {wbm_we_o, wbm_adr_o}, {1'b0, e.adr});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_extra: unexpected result %h", out_data);
                end else begin
                    w = exp_out.pop_front();
                    check("out_data", out_data, w);
                end
            end
            if (done) done_cnt++;
            prev_acc = wbm_stb_o && wbm_ack_i;
            prev_stb = wbm_stb_o;
            prev_req = {wbm_we_o, wbm_adr_o, wbm_dat_o};
        end
    end

    task automatic issue(input logic [31:0] op, input logic [31:0] dims,
                         input logic [15:0] nin, input logic [15:0] nout);
        int g = 0;
        while (!cmd_ready && g < 1000) begin @(posedge clk); #1; g++; end
        check("cmd_ready_before", cmd_ready, 1);
        cmd_op = op; cmd_dims = dims; cmd_n_in = nin; cmd_n_out = nout;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("accept_state", {busy, cmd_ready, err, wbm_stb_o}, 4'b1000);
        @(negedge clk);
        check("first_stb", {wbm_stb_o, wbm_we_o, wbm_adr_o}, {2'b11, BASE});
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input int starve_at);
        int i = 0, g = 0;
        bit hs, starved = 1'b0;
        while (i < n && g < 4000) begin
            if (starve_at >= 0 && i == starve_at && !starved) begin
                starved  = 1'b1;
                in_valid = 1'b0;
                repeat (5) begin @(negedge clk); check("starve_stb", wbm_stb_o, 0); end
                @(posedge clk); #1;
            end
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = opnd_q[i];
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            g++;
            if (hs) begin i++; in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        check("operands_fed", i, n);
    endtask

    task automatic drain(input int n, input bit bp);
        int j = 0, g = 0;
        bit hs;
        logic [31:0] first;
        if (bp && n > 0) begin
            out_ready = 1'b0;
            first = exp_out[0];
            @(negedge clk);
            while (!out_valid && g < 4000) begin @(negedge clk); g++; end
            repeat (10) begin
                check("bp_data", out_data, first);
                check("bp_no_read", {wbm_stb_o, out_valid}, 2'b01);
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        while (j < n && g < 4000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            g++;
            if (hs) j++;
        end
        out_ready = 1'b0;
        check("results_drained", j, n);
    endtask

    task automatic run_job(input logic [31:0] op, input logic [31:0] dims, input int nin,
                           input int nout, input int polls, input int starve_at,
                           input bit bp, input bit no_go_ack);
        int db, g, hi;
        logic [31:0] d;
        salt = $urandom;
        never_ack_go = no_go_ack;
        poll_limit = poll_total + polls;
        opnd_q.delete();
        for (int i = 0; i < nin; i++) opnd_q.push_back($urandom);
        exp_bus.push_back('{1'b1, waddr(HDR_OP), op});
        for (int k = HDR_DIMS_FIRST; k <= HDR_DIMS_LAST; k++) begin
            d = dims >> (8 * (k - 1));
            exp_bus.push_back('{1'b1, waddr(k), {24'b0, d[7:0]}});
        end
        for (int i = 0; i < nin; i++) exp_bus.push_back('{1'b1, waddr(OPND_IDX + i), opnd_q[i]});
        if (!no_go_ack) begin
            exp_bus.push_back('{1'b1, waddr(HDR_GO), GO_WORD});
            for (int p = 0; p <= polls; p++) exp_bus.push_back('{1'b0, waddr(HDR_GO), 32'd0});
            for (int j = 0; j < nout; j++) begin
                exp_bus.push_back('{1'b0, waddr(RES_IDX + j), 32'd0});
                exp_out.push_back(res_word(waddr(RES_IDX + j), salt));
            end
        end
        db = done_cnt;
        issue(op, dims, 16'(nin), 16'(nout));
        feed(nin, starve_at);
        if (no_go_ack) begin
            g = 0;
            @(negedge clk);
            while (!(wbm_stb_o && wbm_adr_o == waddr(HDR_GO)) && g < 200) begin @(negedge clk); g++; end
            hi = 0;
            while (wbm_stb_o && hi < 100) begin hi++; @(negedge clk); end
            check("timeout_len", hi, TMO);
            check("timeout_err", {err, busy, cmd_ready, done}, 4'b1100);
            @(negedge clk);
            check("timeout_idle", {cmd_ready, busy, err}, 3'b101);
            never_ack_go = 1'b0;
            check("timeout_no_done", done_cnt - db, 0);
        end else begin
            drain(nout, bp);
            g = 0;
            while (!cmd_ready && g < 500) begin @(negedge clk); g++; end
            check("idle_return", cmd_ready, 1);
            check("done_once", done_cnt - db, 1);
            check("job_err", err, 0);
        end
        check("bus_queue_empty", exp_bus.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nin, nout;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 0);
        check("rst_stream", {in_ready, out_valid, out_data, busy, done, err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reference job: starve after three operands, backpressure the first result.
        run_job(MATMUL, 32'h0202_0202, 8, 4, 3, 3, 1'b1, 1'b0);

        for (int t = 0; t < 5; t++) begin
            nin  = (t == 0) ? 0 : $urandom_range(1, 10);
            nout = (t == 1) ? 0 : $urandom_range(1, 5);
            run_job($urandom, $urandom, nin, nout, $urandom_range(0, 3), -1, 1'b0, 1'b0);
        end

        run_job(MATMUL, 32'h0102_0304, 2, 2, 0, -1, 1'b0, 1'b1);
        run_job(MATMUL, $urandom, 3, 2, 1, -1, 1'b0, 1'b0);

        // Asynchronous reset while an operand write is strobing.
        exp_bus.delete();
        exp_out.delete();
        for (int k = 0; k < 5; k++) exp_bus.push_back('{1'b1, waddr(k), (k == 0) ? MATMUL : 32'd1});
        for (int i = 0; i < 8; i++) exp_bus.push_back('{1'b1, waddr(OPND_IDX + i), 32'hC0FF_EE00});
        in_data  = 32'hC0FF_EE00;
        in_valid = 1'b1;
        issue(MATMUL, 32'h0101_0101, 16'd8, 16'd2);
        begin
            int g = 0;
            @(negedge clk);
            while (!(wbm_stb_o && wbm_adr_o == waddr(OPND_IDX)) && g < 200) begin @(negedge clk); g++; end
            check("reset_reached_opnd", wbm_adr_o, waddr(OPND_IDX));
        end
        #1 rst_n = 1'b0;
        #1 check("reset_async_drop", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        in_valid = 1'b0;
        exp_bus.delete();
        exp_out.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_recover", {cmd_ready, err, busy}, 3'b100);
        @(posedge clk); #1;

        run_job(MATMUL, 32'h0404_0404, 4, 3, 2, 1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_accel_driver.md
# wb_accel_driver

Wishbone initiator that runs one complete accelerator job over the slave port of the matrix accelerator. On a command it writes the header words, streams operand words into the operand window, writes the go word, and then holds a poll read until the accelerator finishes. It then reads the result window out to a local stream. It sits between a local controller or DMA and the accelerator's Wishbone slave.

## Interface
- `BASE_ADDR`, default 32'h3010_0000: byte address of accelerator word 0.
- `OPND_IDX`, default 6: word index of the first operand word.
- `RES_IDX`, default 64: word index of the first result word.
- `TIMEOUT`, default 4096: maximum cycles to wait for `wbm_ack_i` on one access.
- `wb_clk_i`, in, 1: clock.
- `wb_rst_n_i`, in, 1: asynchronous active-low reset.
- `cmd_valid`, in, 1: a job command is present.
- `cmd_ready`, out, 1: the block is idle and accepts a command.
- `cmd_op`, in, 32: operation code, written to word 0.
- `cmd_dims`, in, 32: four 8-bit dimensions {hb,wb,ha,wa}, zero-extended into words 1..4 (wa goes to word 1).
- `cmd_n_in`, in, 16: number of operand words.
- `cmd_n_out`, in, 16: number of result words.
- `in_data`, in, 32; `in_valid`, in, 1; `in_ready`, out, 1: operand stream.
- `out_data`, out, 32; `out_valid`, out, 1; `out_ready`, in, 1: result stream.
- `wbm_cyc_o`, out, 1; `wbm_stb_o`, out, 1; `wbm_we_o`, out, 1; `wbm_adr_o`, out, 32; `wbm_dat_o`, out, 32: master request outputs.
- `wbm_dat_i`, in, 32; `wbm_ack_i`, in, 1: slave response inputs.
- `busy`, out, 1: a job is in progress.
- `done`, out, 1: one-cycle pulse when a job completes.
- `err`, out, 1: sticky timeout flag, cleared by the next accepted command.

## Operation
- States: IDLE, HDR, OPND, GO, POLL, RES, FIN, ERR.
- IDLE: `cmd_ready`=1. A command is accepted when `cmd_valid`&`cmd_ready`. Acceptance latches the command fields, clears `err`, and moves to HDR.
- HDR: five writes, word k at `BASE_ADDR`+4k for k=0..4. Word 0 carries `cmd_op`; words 1..4 carry the dimensions.
- OPND: `cmd_n_in` writes to `BASE_ADDR`+4*(`OPND_IDX`+i).
  - A write is launched only when `in_valid`=1.
  - `in_ready` pulses for exactly one cycle, coincident with the ack of that write.
  - If `cmd_n_in`=0 the state is skipped.
- GO: one write of 32'hFFFF_FFFF to word 5.
- POLL: one read of word 5, with stb held until ack.
  - Acked data of 0 moves to RES.
  - Any other value re-issues the read after the mandatory gap.
- RES: `cmd_n_out` reads from `BASE_ADDR`+4*(`RES_IDX`+j).
  - Acked data is registered onto `out_data` and `out_valid` is set.
  - The next read is not launched until that word is taken (`out_valid`&`out_ready`).
  - If `cmd_n_out`=0 the state is skipped.
- FIN: pulses `done` and returns to IDLE once the final result word has been accepted.
- Every access has the same shape: cyc=stb=1 with stable adr/dat/we until the ack, then at least one cycle with cyc=stb=0 before the next access. The slave refuses back-to-back strobes, so this gap is mandatory.
- Timeout: a per-access counter runs while stb is high. When it reaches `TIMEOUT` without an ack:
  - cyc and stb drop;
  - `err` is set;
  - the state goes to ERR, then to IDLE on the next cycle;
  - pending stream words are not consumed.
- Counters: 16-bit word counters. Addresses are computed modulo 2^32.

## Timing
- Reset values: `cmd_ready`=1 (state IDLE). All other outputs are 0: `wbm_*`, `in_ready`, `out_valid`, `out_data`, `busy`, `done`, `err`.
- Reset asserted mid-access drops cyc and stb asynchronously. Any job in progress is abandoned.
- Acceptance: the command is accepted at edge N. stb rises at edge N+1 for header word 0.
- Write throughput with a zero-wait slave: 2 cycles per word when the slave acks in the first strobe cycle (1 strobe cycle plus 1 gap). The reference slave acks a cycle later.
- `wbm_ack_i` is only sampled while stb=1. An ack arriving during a gap is ignored.
- `busy`=1 from the acceptance edge through the FIN cycle. It is also 1 in ERR.
- `cmd_valid` while busy is ignored because `cmd_ready`=0.

## Structure
- A shared package `accel_pkg` holds:
  - the state enum;
  - header word indices (OP=0, DIMS=1..4, GO=5);
  - GO_WORD=32'hFFFF_FFFF;
  - the op code MATMUL=1.
- One sub-module, `wb_master_port`, performs a single access. It owns the request/ack handshake, the mandatory gap and the timeout counter, and exposes req/we/adr/wdat → ack/rdat/timeout. The top-level FSM sequences accesses through it.

## Test plan
- Reset mid-OPND (stb=1): `wbm_cyc_o` and `wbm_stb_o` go to 0 immediately; after release, `cmd_ready`=1 and `err`=0.
- Full job with a slave model: op=1, dims {2,2,2,2}, `cmd_n_in`=8, `cmd_n_out`=4.
  - Write addresses are 3010_0000..3010_0010, then 3010_0018..3010_0034, then the GO write to 3010_0014.
  - Four result reads start at 3010_0100.
  - `done` pulses once.
- Poll: the slave returns FFFF_FFFF three times, then 0. Exactly four word-5 reads occur, each separated by an idle cycle.
- Backpressure: hold `out_ready`=0 for 10 cycles after the first result. `out_data` stays stable, no further read is launched, and the remaining words then follow in order.
- Starved input: drop `in_valid` for 5 cycles mid-OPND. stb stays low for those cycles, and no operand word is lost or duplicated.
- Timeout with `TIMEOUT`=16 and a slave that never acks GO. stb drops after 16 cycles; `err`=1, `done`=0, and the block returns to IDLE. The next command clears `err`.
